// File: rtl/t_loop_sequencer_if.sv
// Host/control bundle for t_loop_sequencer: loop launch/config, host array port and status.
// The master side is the host; the slave side is the sequencer.
interface t_loop_sequencer_if #(
    parameter int DW = 4,
    parameter int AW = 2,
    parameter int CW = 8
);
    logic          start;
    logic [CW-1:0] cfg_start;
    logic [CW-1:0] cfg_limit;
    logic [CW-1:0] cfg_step;
    logic [CW-1:0] cfg_floor;
    logic          cfg_floor_en;
    logic [AW-1:0] cfg_src;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] iter_cnt;

    modport master (
        output start, cfg_start, cfg_limit, cfg_step, cfg_floor, cfg_floor_en, cfg_src,
        output host_we, host_addr, host_wdata,
        input  host_rdata, busy, done, err, iter_cnt
    );

    modport slave (
        input  start, cfg_start, cfg_limit, cfg_step, cfg_floor, cfg_floor_en, cfg_src,
        input  host_we, host_addr, host_wdata,
        output host_rdata, busy, done, err, iter_cnt
    );
endinterface

// File: rtl/t_loop_sequencer.sv
// Counted-loop engine: for (i = start; i < limit && (!floor_en || i > floor); i += step)
// mem[i] <= mem[src], sharing a small register array with a host load/read port.
module t_loop_sequencer #(
    parameter int DEPTH = 4,
    parameter int DW    = 4,
    parameter int AW    = 2,
    parameter int CW    = 8
) (
    input  logic              clk,
    input  logic              reset_l,
    t_loop_sequencer_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q,    state_d;
    logic [CW-1:0] i_q,        i_d;
    logic [CW-1:0] limit_q,    limit_d;
    logic [CW-1:0] step_q,     step_d;
    logic [CW-1:0] floor_q,    floor_d;
    logic          floor_en_q, floor_en_d;
    logic [AW-1:0] src_q,      src_d;
    logic [CW-1:0] iter_cnt_q, iter_cnt_d;
    logic          err_q,      err_d;
    logic          ovf_q,      ovf_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;

    logic [DW-1:0] mem [DEPTH];

    logic          cond;
    logic [CW:0]   sum;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        limit_d      = limit_q;
        step_d       = step_q;
        floor_d      = floor_q;
        floor_en_d   = floor_en_q;
        src_d        = src_q;
        iter_cnt_d   = iter_cnt_q;
        err_d        = err_q;
        ovf_d        = ovf_q;
        host_rdata_d = mem[bus.host_addr];
        mem_we       = 1'b0;
        mem_waddr    = bus.host_addr;
        mem_wdata    = bus.host_wdata;

        // ovf_q forces one final non-iterating RUN cycle so the wrapped i is never evaluated
        cond = (i_q < limit_q) && (!floor_en_q || (i_q > floor_q)) && !ovf_q;
        sum  = {1'b0, i_q} + {1'b0, step_q};

        case (state_q)
            ST_IDLE: begin
                mem_we = bus.host_we;
                if (bus.start) begin
                    i_d        = bus.cfg_start;
                    limit_d    = bus.cfg_limit;
                    step_d     = bus.cfg_step;
                    floor_d    = bus.cfg_floor;
                    floor_en_d = bus.cfg_floor_en;
                    src_d      = bus.cfg_src;
                    iter_cnt_d = '0;
                    ovf_d      = 1'b0;
                    if (bus.cfg_step == '0) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (cond) begin
                    if (iter_cnt_q != '1) begin
                        iter_cnt_d = iter_cnt_q + CW'(1);
                    end
                    if (sum[CW]) begin
                        ovf_d = 1'b1;
                    end else begin
                        i_d = sum[CW-1:0];
                    end
                    // Indices beyond the array still count as iterations but write nothing
                    if (i_q[CW-1:AW] == '0) begin
                        mem_we    = 1'b1;
                        mem_waddr = i_q[AW-1:0];
                        mem_wdata = mem[src_q];
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q      <= ST_IDLE;
            i_q          <= '0;
            limit_q      <= '0;
            step_q       <= '0;
            floor_q      <= '0;
            floor_en_q   <= 1'b0;
            src_q        <= '0;
            iter_cnt_q   <= '0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            limit_q      <= limit_d;
            step_q       <= step_d;
            floor_q      <= floor_d;
            floor_en_q   <= floor_en_d;
            src_q        <= src_d;
            iter_cnt_q   <= iter_cnt_d;
            err_q        <= err_d;
            ovf_q        <= ovf_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // Array contents survive reset; only a write in flight at the reset edge is blocked
    always_ff @(posedge clk) begin
        if (reset_l && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.err        = err_q;
    assign bus.iter_cnt   = iter_cnt_q;
    assign bus.host_rdata = host_rdata_q;
endmodule

// File: doc/t_loop_sequencer.md
# t_loop_sequencer

Hardware loop sequencer that owns a small DEPTH x DW register array and executes a programmable counted loop over it. The loop is `for (i = start; cond(i); i += step) mem[i] <= mem[src]`, where `cond` is `i < limit`, optionally ANDed with `i > floor`. The block gives the compound-condition loop semantics a cycle-accurate hardware form, and it arbitrates array access between a host load/read port and the loop engine. It sits beside the loop-unroll regression tests as the sequenced counterpart of a compound-condition for loop.

## Interface
Parameters:
- DEPTH, 4, number of array words (power of two, >= 2)
- DW, 4, array word width
- AW, 2, array index width, equal to clog2(DEPTH)
- CW, 8, loop index / iteration counter width

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset_l  in  1  synchronous active-low reset, sampled on the rising edge of clk
- start  in  1  launch request; accepted only in IDLE
- cfg_start  in  CW  initial value of i
- cfg_limit  in  CW  exclusive upper bound: loop continues only while i < limit
- cfg_step  in  CW  increment added to i each iteration; 0 is illegal
- cfg_floor  in  CW  lower guard value: loop continues only while i > floor
- cfg_floor_en  in  1  1 = include the `i > floor` term in cond
- cfg_src  in  AW  source word index for the loop body
- host_we  in  1  host write strobe
- host_addr  in  AW  host write/read address
- host_wdata  in  DW  host write data
- host_rdata  out  DW  registered read of mem[host_addr]
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse
- err  out  1  high with done when the launch was aborted
- iter_cnt  out  CW  number of body executions in the last loop; saturates at all-ones

## Operation
- All cfg_* inputs are captured into shadow registers on the accepting cycle. Changes to cfg_* while busy have no effect.
- States and transitions:
  - IDLE: start=1 latches the config and moves to RUN. If cfg_step=0, the block goes straight to DONE with err=1 and iter_cnt=0.
  - RUN: evaluates cond(i) once per cycle.
    - If cond(i) is true: the body executes, i <= i + step, iter_cnt increments, and the block stays in RUN.
    - If cond(i) is false: the block goes to DONE.
  - DONE: done=1 for exactly one cycle, then the block returns to IDLE.
- cond(i) is `(i < limit) && (!floor_en || i > floor)`, compared unsigned. If cond is false on the first RUN cycle, the loop runs zero iterations.
- Body write rules:
  - The body writes mem[i[AW-1:0]] <= mem[src], using the array value at the start of that cycle.
  - If i >= DEPTH, the write is suppressed but still counted as an iteration.
  - When i == src, the body rewrites the word with its own value (no change).
- Overflow rule: if i + step carries out of CW bits, the loop ends after the current iteration. The wrapped value is never evaluated. This guarantees the loop terminates.
- Host port:
  - host_we is honoured only in IDLE and is silently dropped while busy.
  - host_rdata is valid in every state.
- The array is not cleared by reset. Only the control registers are reset.

## Timing
- Reset values (reset_l=0 at an edge): state=IDLE, busy=0, done=0, err=0, iter_cnt=0, host_rdata=0, i=0.
- Reset mid-loop: the block returns to IDLE at that edge. No further body writes occur, and writes already performed remain in the array.
- Launch sequence: start is sampled at edge E0, and busy=1 from E0+1.
- An N-iteration loop spends N+1 cycles in RUN, then 1 cycle in DONE. done is high during cycle E0+N+2, and busy falls at E0+N+3.
- iter_cnt is cleared at launch and is final and stable when done=1. It holds its value until the next launch.
- err is valid only while done=1 and is 0 at all other times.
- start while busy is ignored; start must be re-asserted after the block returns to IDLE. start held high in IDLE relaunches on the first IDLE cycle.
- Host reads: host_rdata reflects mem[host_addr] one cycle after the address is presented, including any loop or host write completed at the preceding edge.
- Simultaneous events:
  - A host write and a start in the same IDLE cycle: the write completes, and the loop sees the new value.
  - start with reset_l=0: reset wins.

## Test plan
- Preload mem = {0,?,2,3}; launch start=0, limit=4, floor=1, floor_en=1, step=1, src=0 -> zero iterations, done 2 cycles after the launch edge, iter_cnt=0, mem[0]=0 and mem[3]=3 unchanged.
- Launch start=1, limit=3, step=1, floor_en=0 -> iter_cnt=2, done at E0+4. Repeat with start=2, limit=4, src=0 -> mem[2]=mem[3]=0.
- Launch start=0, limit=9, step=3, src=1 with mem[1]=5 -> iterations at i=0,3,6, so iter_cnt=3. mem[0]=mem[3]=5, and the write at i=6 is suppressed (6 >= DEPTH).
- Launch step=0 -> done and err high together on the cycle after acceptance, iter_cnt=0, array unchanged.
- Launch start=250, limit=255, step=4, floor_en=0 (CW=8) -> one iteration at i=250, then 254 -> second iteration, then overflow ends the loop: iter_cnt=2, no hang.
- Launch a 3-iteration loop and assert reset_l=0 in the second RUN cycle -> busy=0 next cycle, no done pulse, exactly one body write applied. A host_we during RUN is dropped.
